// File: rtl/dla_ppp_reader.sv
// dla_ppp_reader: drains one full ppp bank per start request, tile by tile and row by row, into a FWFT FIFO.
// Latency start->ren 3 cycles, ren->valid 2 cycles; reads stall once FIFO occupancy plus in-flight reaches FIFO_DEPTH.

module dla_ppp_fifo #(
  parameter int DAT_W = 8,
  parameter int TAG_W = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_vld,
  input  logic [DAT_W-1:0]         push_dat,
  input  logic [TAG_W-1:0]         push_tag,
  input  logic                     pop_rdy,
  output logic                     head_vld,
  output logic [DAT_W-1:0]         head_dat,
  output logic [TAG_W-1:0]         head_tag,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [DAT_W-1:0] mem [DEPTH];
  logic [TAG_W-1:0] tag [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop;

  assign head_vld = (count != '0);
  assign pop      = pop_rdy & head_vld;
  // Head is masked while empty so stale storage never reaches the consumer.
  assign head_dat = head_vld ? mem[rd_ptr] : '0;
  assign head_tag = head_vld ? tag[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) tag[i] <= '0;
    end else begin
      if (push_vld) begin
        tag[wr_ptr] <= push_tag;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_vld, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module dla_ppp_reader #(
  parameter int DLA_DATA_WIDTH = 1024,
  parameter int DLA_ADDR_WIDTH = 10,
  parameter int TILE_NUM       = 32,
  parameter int ROW_NUM        = 8,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic                      dla_rdy_i,
  output logic                      dla_resp_o,
  output logic                      dla_ren_o,
  output logic [DLA_ADDR_WIDTH-1:0] dla_raddr_o,
  input  logic [DLA_DATA_WIDTH-1:0] dla_rdata_i,
  output logic                      dla_done_o,
  output logic [DLA_DATA_WIDTH-1:0] data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      last_o,
  output logic                      busy_o
);
  localparam int TW = $clog2(TILE_NUM);
  localparam int RW = $clog2(ROW_NUM);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {IDLE, WAIT_RDY, RESP, READ, DRAIN, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] tile_cnt;
  logic [RW-1:0] row_cnt;
  logic          inflight;
  logic          inflight_last;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   used;
  logic          has_credit;
  logic          final_addr;
  logic          fifo_empty;

  assign final_addr = (tile_cnt == TW'(TILE_NUM - 1)) && (row_cnt == RW'(ROW_NUM - 1));
  // Occupancy counts the read already on the bus so its data always has a slot.
  assign used       = {1'b0, fifo_count} + (CW+1)'(inflight);
  assign has_credit = (used < (CW+1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);

  assign dla_raddr_o = DLA_ADDR_WIDTH'({tile_cnt, row_cnt});
  assign busy_o      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    dla_resp_o = 1'b0;
    dla_ren_o  = 1'b0;
    dla_done_o = 1'b0;
    case (state)
      IDLE:     if (start_i) state_nxt = WAIT_RDY;
      WAIT_RDY: if (dla_rdy_i) state_nxt = RESP;
      RESP: begin
        dla_resp_o = 1'b1;
        state_nxt  = READ;
      end
      READ: begin
        dla_ren_o = has_credit;
        if (has_credit && final_addr) state_nxt = DRAIN;
      end
      DRAIN:    if (!inflight && fifo_empty) state_nxt = DONE;
      DONE: begin
        dla_done_o = 1'b1;
        state_nxt  = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // Row is the fast index; both counters wrap to zero after the final word.
  always_ff @(posedge clk) begin
    if (!rst_n || state == DONE) begin
      tile_cnt <= '0;
      row_cnt  <= '0;
    end else if (dla_ren_o) begin
      if (row_cnt == RW'(ROW_NUM - 1)) begin
        row_cnt  <= '0;
        tile_cnt <= tile_cnt + 1'b1;
      end else begin
        row_cnt <= row_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= dla_ren_o;
      inflight_last <= dla_ren_o & final_addr;
    end
  end

  dla_ppp_fifo #(
    .DAT_W (DLA_DATA_WIDTH),
    .TAG_W (1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (inflight),
    .push_dat (dla_rdata_i),
    .push_tag (inflight_last),
    .pop_rdy  (ready_i),
    .head_vld (valid_o),
    .head_dat (data_o),
    .head_tag (last_o),
    .count    (fifo_count)
  );
endmodule

// File: tb/tb_dla_ppp_reader.sv
// Bench for dla_ppp_reader: ppp bank model, beat/read logger and directed scenarios with random data and backpressure.
module tb_dla_ppp_reader;
  localparam int DW  = 1024;
  localparam int AW  = 10;
  localparam int NB  = 256;
  localparam int SDW = 32;
  localparam int SNB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, dla_rdy, ready;
  logic          resp, ren, done, valid, last, busy;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata, data, junk;
  logic [DW-1:0] bank_mem [NB];

  logic           s_start, s_rdy, s_ready;
  logic           s_resp, s_ren, s_done, s_valid, s_last, s_busy;
  logic [AW-1:0]  s_raddr;
  logic [SDW-1:0] s_rdata, s_data;
  logic [SDW-1:0] s_mem [SNB];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  dla_ppp_reader dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .dla_rdy_i(dla_rdy),
    .dla_resp_o(resp), .dla_ren_o(ren), .dla_raddr_o(raddr), .dla_rdata_i(rdata),
    .dla_done_o(done), .data_o(data), .valid_o(valid), .ready_i(ready),
    .last_o(last), .busy_o(busy)
  );

  dla_ppp_reader #(
    .DLA_DATA_WIDTH(SDW), .DLA_ADDR_WIDTH(AW), .TILE_NUM(4), .ROW_NUM(2), .FIFO_DEPTH(2)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .start_i(s_start), .dla_rdy_i(s_rdy),
    .dla_resp_o(s_resp), .dla_ren_o(s_ren), .dla_raddr_o(s_raddr), .dla_rdata_i(s_rdata),
    .dla_done_o(s_done), .data_o(s_data), .valid_o(s_valid), .ready_i(s_ready),
    .last_o(s_last), .busy_o(s_busy)
  );

  // ppp bank models: data appears the cycle after a read enable
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rdata   <= (ren && raddr < AW'(NB)) ? bank_mem[raddr[7:0]] : junk;
    s_rdata <= (s_ren && s_raddr < AW'(SNB)) ? s_mem[s_raddr[2:0]] : ~s_mem[0];
  end

  logic [AW-1:0]  ren_q[$];
  int             ren_cyc_q[$];
  logic [DW-1:0]  beat_q[$];
  logic           beat_last_q[$];
  int             beat_cyc_q[$];
  int             n_resp = 0, n_done = 0, resp_cyc = -1, done_cyc = -1, max_out = 0;
  logic [AW-1:0]  s_ren_q[$];
  logic [SDW-1:0] s_beat_q[$];
  logic           s_last_q[$];
  int             s_beat_cyc_q[$];
  int             s_n_done = 0, s_done_cyc = -1;

  always @(negedge clk) begin
    if (ren) begin
      ren_q.push_back(raddr);
      ren_cyc_q.push_back(cyc);
      if (ren_q.size() - beat_q.size() > max_out) max_out = ren_q.size() - beat_q.size();
    end
    if (valid && ready) begin
      beat_q.push_back(data);
      beat_last_q.push_back(last);
      beat_cyc_q.push_back(cyc);
    end
    if (resp) begin n_resp++; resp_cyc = cyc; end
    if (done) begin n_done++; done_cyc = cyc; end
    if (s_ren) s_ren_q.push_back(s_raddr);
    if (s_valid && s_ready) begin
      s_beat_q.push_back(s_data);
      s_last_q.push_back(s_last);
      s_beat_cyc_q.push_back(cyc);
    end
    if (s_done) begin s_n_done++; s_done_cyc = cyc; end
  end

  task automatic chk(string tag, longint obs, longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkd(string tag, int idx, logic [DW-1:0] obs, logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d]: observed=%h.. expected=%h..", tag, idx, obs[63:0], exp[63:0]);
    end
  endtask

  task automatic clear_log();
    ren_q.delete(); ren_cyc_q.delete(); beat_q.delete(); beat_last_q.delete(); beat_cyc_q.delete();
    n_resp = 0; n_done = 0; resp_cyc = -1; done_cyc = -1; max_out = 0;
  endtask

  task automatic fill_random();
    for (int a = 0; a < NB; a++)
      for (int w = 0; w < DW/32; w++) bank_mem[a][w*32 +: 32] = $urandom;
  endtask

  task automatic pulse_start(output int sc);
    @(posedge clk); #1;
    start = 1'b1;
    sc = cyc;
  endtask

  // mode 1: random ready with a 50-cycle stall; restart_at: iteration for a stray start
  task automatic run(int mode, int restart_at);
    int extra;
    extra = -1;
    for (int i = 0; i < 4000 && extra != 0; i++) begin
      @(posedge clk); #1;
      start = (i == restart_at);
      if (mode == 1) ready = (i >= 150 && i < 200) ? 1'b0 : 1'($urandom & 1);
      if (extra > 0) extra--;
      if (extra < 0 && n_done != 0) extra = 10;
    end
    start = 1'b0;
    ready = 1'b1;
  endtask

  task automatic check_bank(string tag);
    int nb, nlast;
    chk({tag, "_nren"}, ren_q.size(), NB);
    chk({tag, "_nbeat"}, beat_q.size(), NB);
    for (int i = 0; i < ren_q.size(); i++) begin
      nb = bad;
      chk({tag, "_addr"}, ren_q[i], i);
      if (bad != nb) break;
    end
    for (int i = 0; i < beat_q.size() && i < NB; i++) begin
      nb = bad;
      chkd({tag, "_data"}, i, beat_q[i], bank_mem[i]);
      if (bad != nb) break;
    end
    nlast = 0;
    foreach (beat_last_q[i]) nlast += int'(beat_last_q[i]);
    chk({tag, "_nlast"}, nlast, 1);
    if (beat_q.size() == NB) begin
      chk({tag, "_last_on_final"}, beat_last_q[NB-1], 1);
      chk({tag, "_done_lat"}, done_cyc, beat_cyc_q[NB-1] + 2);
    end
    chk({tag, "_nresp"}, n_resp, 1);
    chk({tag, "_ndone"}, n_done, 1);
  endtask

  initial begin
    int sc, rise, wait_i;
    rst_n = 1'b0; start = 1'b0; dla_rdy = 1'b0; ready = 1'b1;
    s_start = 1'b0; s_rdy = 1'b1; s_ready = 1'b1;
    for (int w = 0; w < DW/32; w++) junk[w*32 +: 32] = $urandom;
    for (int a = 0; a < NB; a++) bank_mem[a] = {128{8'(a >> 3)}};
    for (int a = 0; a < SNB; a++) s_mem[a] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid, 0); chk("rst_last", last, 0); chk("rst_busy", busy, 0);
    chk("rst_ren", ren, 0);     chk("rst_resp", resp, 0); chk("rst_done", done, 0);
    chk("rst_raddr", raddr, 0); chkd("rst_data", 0, data, '0);
    chk("rst_s_valid", s_valid, 0);
    rst_n = 1'b1;

    // basic bank, tile t holds byte t
    dla_rdy = 1'b1;
    clear_log();
    pulse_start(sc);
    run(0, -1);
    check_bank("basic");
    chk("basic_resp_lat", resp_cyc, sc + 2);
    if (ren_cyc_q.size() == NB) begin
      chk("basic_first_ren", ren_cyc_q[0], sc + 3);
      chk("basic_no_bubble", ren_cyc_q[NB-1] - ren_cyc_q[0], NB - 1);
      chk("basic_ren_to_beat", beat_cyc_q[0], ren_cyc_q[0] + 2);
    end

    // ppp bank not ready for 20 cycles
    fill_random();
    dla_rdy = 1'b0;
    clear_log();
    pulse_start(sc);
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; start = 1'b0; end
    chk("rdyw_nren", ren_q.size(), 0);
    chk("rdyw_nresp", n_resp, 0);
    chk("rdyw_busy", busy, 1);
    dla_rdy = 1'b1;
    rise = cyc;
    run(0, -1);
    chk("rdyw_resp_lat", resp_cyc, rise + 1);
    if (ren_cyc_q.size() > 0) chk("rdyw_first_ren", ren_cyc_q[0], rise + 2);
    check_bank("rdyw");

    // random backpressure with a long stall
    fill_random();
    clear_log();
    pulse_start(sc);
    run(1, -1);
    check_bank("bp");
    chk("bp_max_outstanding", max_out, 4);

    // stray start mid-READ, then a fresh bank
    fill_random();
    clear_log();
    pulse_start(sc);
    run(0, 60);
    check_bank("busy_start");
    chk("busy_start_idle", busy, 0);
    fill_random();
    clear_log();
    pulse_start(sc);
    run(0, -1);
    check_bank("second_bank");

    // reset at beat 100
    fill_random();
    clear_log();
    pulse_start(sc);
    wait_i = 0;
    while (beat_q.size() < 100 && wait_i < 1000) begin
      @(posedge clk); #1; start = 1'b0; wait_i++;
    end
    chk("mid_reached_100", beat_q.size(), 100);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_valid", valid, 0); chk("mid_last", last, 0); chk("mid_busy", busy, 0);
    chk("mid_ren", ren, 0);     chk("mid_resp", resp, 0); chk("mid_done", done, 0);
    chk("mid_raddr", raddr, 0); chkd("mid_data", 0, data, '0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_no_done", n_done, 0);
    chk("mid_stale_valid", valid, 0);
    clear_log();
    pulse_start(sc);
    run(0, -1);
    check_bank("after_rst");

    // small instance: 4 tiles x 2 rows, 2-entry FIFO
    @(posedge clk); #1;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    wait_i = 0;
    while (s_n_done == 0 && wait_i < 200) begin @(posedge clk); #1; wait_i++; end
    repeat (5) @(posedge clk);
    #1;
    chk("small_nren", s_ren_q.size(), SNB);
    chk("small_nbeat", s_beat_q.size(), SNB);
    chk("small_ndone", s_n_done, 1);
    for (int i = 0; i < s_ren_q.size(); i++) chk("small_addr", s_ren_q[i], i);
    for (int i = 0; i < s_beat_q.size() && i < SNB; i++) begin
      chk("small_data", s_beat_q[i], s_mem[i]);
      chk("small_last", s_last_q[i], (i == SNB - 1) ? 1 : 0);
    end
    if (s_beat_q.size() == SNB) chk("small_done_lat", s_done_cyc, s_beat_cyc_q[SNB-1] + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
